mem_arb: RTL and testbench
==========================

Name: mem_arb

Overview:
Sequences and arbitrates the single-port SISC main memory between two requesters: the instruction-fetch port, which drives IR load, and the data port, which serves LOD/STR in the mem stage. Each requester sees a request/acknowledge handshake. mem_arb owns all memory enables and hides the fixed memory read latency behind a wait-state counter. It sits between ctrl/datapath and the memory model.

Parameters:
AW, 16, address width of all address ports
DW, 32, data width of all data ports
MEM_LAT, 2, cycles from the mem_en cycle to valid mem_rdata; legal range 1..15

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_f  input  1  synchronous reset, active-high
if_req  input  1  fetch request, held until if_ack
if_addr  input  AW  fetch address, stable while if_req high
if_rdata  output  DW  fetched word, valid in if_ack cycle, held until next if_ack
if_ack  output  1  one-cycle completion pulse, fetch port
dm_req  input  1  data request, held until dm_ack
dm_we  input  1  1 = store, 0 = load; stable while dm_req high
dm_addr  input  AW  data address
dm_wdata  input  DW  store data
dm_rdata  output  DW  load data, valid in dm_ack cycle, held until next dm_ack load
dm_ack  output  1  one-cycle completion pulse, data port
mem_en  output  1  memory access strobe, exactly one cycle per access
mem_we  output  1  memory write strobe, only ever high together with mem_en
mem_addr  output  AW  memory address, registered, stable from mem_en until done
mem_wdata  output  DW  memory write data
mem_rdata  input  DW  memory read data
busy  output  1  high in every state except IDLE
owner  output  2  0 none, 1 fetch, 2 data

Behaviour:
- Reset (rst_f=1 at clock edge): state IDLE; mem_en, mem_we, if_ack, dm_ack, busy = 0; owner = 0; if_rdata, dm_rdata, mem_addr, mem_wdata = 0; wait counter = 0. A reset mid-access abandons it: no ack is ever issued and memory sees no further strobe.
- FSM states:
  - IDLE: sample requests.
    - If no request, stay in IDLE.
    - Otherwise pick a winner, latch its address, write data and we, set owner, and go to ACCESS.
    - Fixed priority: dm beats if.
  - ACCESS: mem_en=1 for exactly this cycle (mem_we=dm_we for data owner, 0 for fetch); load counter with MEM_LAT-1; go to WAIT.
  - WAIT: decrement the counter each cycle. In the cycle where mem_rdata is valid (MEM_LAT cycles after ACCESS), capture mem_rdata into the owner's rdata register (loads and fetches only; stores leave dm_rdata unchanged), then go to DONE.
  - DONE: pulse the owner's ack for one cycle; owner stays valid; go to IDLE.
- Latency: request seen in IDLE at cycle t, then mem_en at t+1, ack at t+2+MEM_LAT, back in IDLE at t+3+MEM_LAT. Stores use identical timing.
- Requests are ignored outside IDLE. A requester must drop req in the cycle after its ack. A req still high when the FSM re-enters IDLE is a new access.
- Minimum one IDLE cycle between accesses; throughput is one access per MEM_LAT+3 cycles.
- Simultaneous if_req and dm_req in IDLE: the winner is served and the loser waits, with its req held, until the next IDLE.
- A request arriving during an access is not lost; it is held by the requester and arbitrated at the next IDLE.
- MEM_LAT=1: WAIT lasts exactly one cycle (counter loaded with 0).
- Counter width: 4 bits. Illegal MEM_LAT is caught by an elaboration-time check.
- owner returns to 0 in IDLE.

Optional Feature:
MEM_ARB_RR_EN.
- Defined: round-robin arbitration. A one-bit last-owner register (reset to fetch) is updated in DONE. On simultaneous requests the port that did not win last time wins.
- Undefined: fixed data-over-fetch priority; no last-owner register exists.

Decomposition:
- Shared package sisc_pkg:
  - state encoding ST_IDLE/ST_ACCESS/ST_WAIT/ST_DONE
  - owner codes OWN_NONE/OWN_IF/OWN_DM
  - LAT_W=4
- One sub-module, mem_arb_pick: a combinational winner select from if_req, dm_req and last-owner. Its round-robin input is tied off when MEM_ARB_RR_EN is undefined.

Test Plan:
1. MEM_LAT=2, if_req with if_addr=0x0010, memory returns 0xDEADBEEF: mem_en at t+1 with mem_addr=0x0010 and mem_we=0; if_ack single pulse at t+4 with if_rdata=0xDEADBEEF; busy low at t+5.
2. Store with dm_we=1, dm_addr=0x0200, dm_wdata=0x12345678: one mem_en/mem_we cycle carrying that address and data; dm_ack at t+4; dm_rdata unchanged.
3. if_req and dm_req rise in the same cycle with fixed priority: data served first (owner=2) and fetch next (owner=1). With MEM_ARB_RR_EN after a data win, fetch wins the next tie.
4. rst_f asserted during WAIT: next cycle state IDLE and all outputs at reset values; no ack ever pulses for the abandoned access; memory sees no second mem_en.
5. MEM_LAT=1 and MEM_LAT=15: ack exactly MEM_LAT+2 cycles after the request; exactly one mem_en per access.
6. Requester holds if_req high for two back-to-back fetches: two mem_en pulses MEM_LAT+3 cycles apart, two if_ack pulses, and an IDLE cycle between accesses.

Source files
------------

// File: rtl/sisc_pkg.sv
// Shared SISC definitions: arbiter state encoding, owner codes and wait-counter width.
package sisc_pkg;

    localparam int LAT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between fetch and data requests.
// last_dm=0 gives data-over-fetch priority on a tie; last_dm=1 hands the tie to fetch.
module mem_arb_pick
    import sisc_pkg::*;
(
    input  logic   if_req,
    input  logic   dm_req,
    input  logic   last_dm,
    output owner_t grant
);

    always_comb begin
        grant = OWN_NONE;
        if (if_req && dm_req) begin
            grant = last_dm ? OWN_IF : OWN_DM;
        end else if (dm_req) begin
            grant = OWN_DM;
        end else if (if_req) begin
            grant = OWN_IF;
        end
    end

endmodule

// File: rtl/mem_arb.sv
// Single-port memory sequencer/arbiter for the fetch and data ports of SISC.
// Define MEM_ARB_RR_EN for round-robin tie-break instead of fixed data-over-fetch priority.
//
// state     | meaning
// ST_IDLE   | no access; arbitrate requests, latch winner's address/data/we
// ST_ACCESS | mem_en strobe for exactly this cycle, load wait counter
// ST_WAIT   | count down memory latency; capture mem_rdata when counter is 0
// ST_DONE   | one-cycle ack to the owner, then back to idle
module mem_arb
    import sisc_pkg::*;
#(
    parameter int AW      = 16,
    parameter int DW      = 32,
    parameter int MEM_LAT = 2
) (
    input  logic          clk,
    input  logic          rst_f,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ack,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_ack,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic [1:0]    owner
);

    if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_lat
        $error("mem_arb: MEM_LAT must lie in 1..15");
    end

    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT - 1);

    state_t            state_q, state_d;
    owner_t            owner_q, owner_d;
    logic [LAT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [AW-1:0]     mem_addr_q, mem_addr_d;
    logic [DW-1:0]     mem_wdata_q, mem_wdata_d;
    logic [DW-1:0]     if_rdata_q, if_rdata_d;
    logic [DW-1:0]     dm_rdata_q, dm_rdata_d;
    logic              if_ack_q, if_ack_d;
    logic              dm_ack_q, dm_ack_d;
    logic              busy_q, busy_d;
    owner_t            grant;
    logic              last_dm;

`ifdef MEM_ARB_RR_EN
    logic last_dm_q, last_dm_d;

    always_comb begin
        last_dm_d = last_dm_q;
        if (state_q == ST_DONE) begin
            last_dm_d = (owner_q == OWN_DM);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_f) begin
            last_dm_q <= 1'b0;
        end else begin
            last_dm_q <= last_dm_d;
        end
    end

    assign last_dm = last_dm_q;
`else
    assign last_dm = 1'b0;
`endif

    mem_arb_pick u_pick (
        .if_req  (if_req),
        .dm_req  (dm_req),
        .last_dm (last_dm),
        .grant   (grant)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_ack_d    = 1'b0;
        dm_ack_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                owner_d = OWN_NONE;
                if (grant != OWN_NONE) begin
                    state_d  = ST_ACCESS;
                    owner_d  = grant;
                    mem_en_d = 1'b1;
                    if (grant == OWN_DM) begin
                        we_d        = dm_we;
                        mem_we_d    = dm_we;
                        mem_addr_d  = dm_addr;
                        mem_wdata_d = dm_wdata;
                    end else begin
                        we_d       = 1'b0;
                        mem_addr_d = if_addr;
                    end
                end
            end
            ST_ACCESS: begin
                state_d = ST_WAIT;
                cnt_d   = LAT_LOAD;
            end
            ST_WAIT: begin
                // counter reaches 0 exactly in the cycle mem_rdata is valid
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                    if (owner_q == OWN_IF) begin
                        if_rdata_d = mem_rdata;
                        if_ack_d   = 1'b1;
                    end else begin
                        if (!we_q) begin
                            dm_rdata_d = mem_rdata;
                        end
                        dm_ack_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - LAT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                owner_d = OWN_NONE;
            end
            default: begin
                state_d = ST_IDLE;
                owner_d = OWN_NONE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst_f) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_NONE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_ack_q    <= if_ack_d;
            dm_ack_q    <= dm_ack_d;
            busy_q      <= busy_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_ack    = if_ack_q;
    assign dm_ack    = dm_ack_q;
    assign busy      = busy_q;
    assign owner     = owner_q;

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb at MEM_LAT=2, plus MEM_LAT=1 and MEM_LAT=15 instances for latency edges.
module tb_mem_arb;

    localparam int AW = 16;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_f;
    logic          if_req, dm_req, dm_we;
    logic [AW-1:0] if_addr, dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] if_rdata, dm_rdata, mem_wdata, mem_rdata;
    logic          if_ack, dm_ack, mem_en, mem_we, busy;
    logic [AW-1:0] mem_addr;
    logic [1:0]    owner;
    logic [DW-1:0] mem_val;

    // MEM_LAT=1 and MEM_LAT=15 instances: fetch-only traffic
    logic          a_if_req, b_if_req;
    logic [DW-1:0] a_if_rdata, b_if_rdata, a_dm_rdata, b_dm_rdata;
    logic [DW-1:0] a_mem_wdata, b_mem_wdata, a_mem_rdata, b_mem_rdata;
    logic          a_if_ack, b_if_ack, a_dm_ack, b_dm_ack;
    logic          a_mem_en, b_mem_en, a_mem_we, b_mem_we, a_busy, b_busy;
    logic [AW-1:0] a_mem_addr, b_mem_addr;
    logic [1:0]    a_owner, b_owner;

    mem_arb #(.AW(AW), .DW(DW), .MEM_LAT(2)) dut (
        .clk(clk), .rst_f(rst_f),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
    );

    mem_arb #(.AW(AW), .DW(DW), .MEM_LAT(1)) dut_l1 (
        .clk(clk), .rst_f(rst_f),
        .if_req(a_if_req), .if_addr(if_addr), .if_rdata(a_if_rdata), .if_ack(a_if_ack),
        .dm_req(1'b0), .dm_we(1'b0), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(a_dm_rdata), .dm_ack(a_dm_ack),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
        .mem_rdata(a_mem_rdata), .busy(a_busy), .owner(a_owner)
    );

    mem_arb #(.AW(AW), .DW(DW), .MEM_LAT(15)) dut_l15 (
        .clk(clk), .rst_f(rst_f),
        .if_req(b_if_req), .if_addr(if_addr), .if_rdata(b_if_rdata), .if_ack(b_if_ack),
        .dm_req(1'b0), .dm_we(1'b0), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(b_dm_rdata), .dm_ack(b_dm_ack),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata), .busy(b_busy), .owner(b_owner)
    );

    // Memory models: read data is valid only in the cycle exactly MEM_LAT after mem_en.
    logic [15:0] hist0 = '0, hist1 = '0, hist15 = '0;
    always @(posedge clk) begin
        hist0  <= {hist0[14:0], mem_en};
        hist1  <= {hist1[14:0], a_mem_en};
        hist15 <= {hist15[14:0], b_mem_en};
    end
    assign mem_rdata   = hist0[1]   ? mem_val : 32'hBAD0_BAD0;
    assign a_mem_rdata = hist1[0]   ? mem_val : 32'hBAD0_BAD0;
    assign b_mem_rdata = hist15[14] ? mem_val : 32'hBAD0_BAD0;

    int en_cnt0 = 0, en_cnt1 = 0, en_cnt15 = 0, ifack_cnt = 0, dmack_cnt = 0, we_bad = 0;
    always @(posedge clk) begin
        if (mem_en)   en_cnt0  <= en_cnt0 + 1;
        if (a_mem_en) en_cnt1  <= en_cnt1 + 1;
        if (b_mem_en) en_cnt15 <= en_cnt15 + 1;
        if (if_ack)   ifack_cnt <= ifack_cnt + 1;
        if (dm_ack)   dmack_cnt <= dmack_cnt + 1;
        if ((mem_we && !mem_en) || (a_mem_we && !a_mem_en) || (b_mem_we && !b_mem_en))
            we_bad <= we_bad + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_f = 1'b1; if_req = 0; dm_req = 0; dm_we = 0; a_if_req = 0; b_if_req = 0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_val = '0;
        tick(3);
        rst_f = 1'b0;
        tick(1);
        checks++; if ({busy, owner, mem_en, mem_we, if_ack, dm_ack} !== 7'd0) begin
            errors++; $display("FAIL reset_ctrl got %b exp 0000000", {busy, owner, mem_en, mem_we, if_ack, dm_ack}); end
        checks++; if ({if_rdata, dm_rdata, mem_wdata} !== 96'd0) begin
            errors++; $display("FAIL reset_data got %h %h %h exp 0", if_rdata, dm_rdata, mem_wdata); end
        checks++; if (mem_addr !== 16'h0000) begin
            errors++; $display("FAIL reset_addr got %h exp 0000", mem_addr); end
    endtask

    task automatic test_fetch();
        mem_val = 32'hDEAD_BEEF; if_addr = 16'h0010; if_req = 1'b1;
        tick(1);
        checks++; if ({mem_en, mem_we, owner} !== 4'b1001) begin
            errors++; $display("FAIL fetch_strobe got en=%b we=%b own=%0d exp en=1 we=0 own=1", mem_en, mem_we, owner); end
        checks++; if (mem_addr !== 16'h0010) begin
            errors++; $display("FAIL fetch_addr got %h exp 0010", mem_addr); end
        tick(1);
        checks++; if (mem_en !== 1'b0) begin
            errors++; $display("FAIL fetch_en_single got %b exp 0", mem_en); end
        tick(1);
        checks++; if (if_ack !== 1'b0) begin
            errors++; $display("FAIL fetch_ack_early got %b exp 0", if_ack); end
        tick(1);
        checks++; if (if_ack !== 1'b1) begin
            errors++; $display("FAIL fetch_ack got %b exp 1", if_ack); end
        checks++; if (if_rdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL fetch_rdata got %h exp deadbeef", if_rdata); end
        if_req = 1'b0;
        tick(1);
        checks++; if ({busy, if_ack, owner} !== 4'b0000) begin
            errors++; $display("FAIL fetch_idle got busy=%b ack=%b own=%0d exp 0 0 0", busy, if_ack, owner); end
        checks++; if (if_rdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL fetch_rdata_hold got %h exp deadbeef", if_rdata); end
    endtask

    task automatic test_store();
        mem_val = 32'hCAFE_F00D;
        dm_we = 1'b1; dm_addr = 16'h0200; dm_wdata = 32'h1234_5678; dm_req = 1'b1;
        tick(1);
        checks++; if ({mem_en, mem_we, owner} !== 4'b1110) begin
            errors++; $display("FAIL store_strobe got en=%b we=%b own=%0d exp en=1 we=1 own=2", mem_en, mem_we, owner); end
        checks++; if (mem_addr !== 16'h0200 || mem_wdata !== 32'h1234_5678) begin
            errors++; $display("FAIL store_addr_data got %h %h exp 0200 12345678", mem_addr, mem_wdata); end
        tick(1);
        checks++; if ({mem_en, mem_we} !== 2'b00) begin
            errors++; $display("FAIL store_strobe_end got %b exp 00", {mem_en, mem_we}); end
        tick(2);
        checks++; if (dm_ack !== 1'b1) begin
            errors++; $display("FAIL store_ack got %b exp 1", dm_ack); end
        checks++; if (dm_rdata !== 32'h0) begin
            errors++; $display("FAIL store_rdata_keep got %h exp 00000000", dm_rdata); end
        dm_req = 1'b0; dm_we = 1'b0;
        tick(1);
        checks++; if ({busy, dm_ack} !== 2'b00) begin
            errors++; $display("FAIL store_idle got %b exp 00", {busy, dm_ack}); end
    endtask

    task automatic test_tie();
        logic [1:0] exp_first;
        mem_val = 32'h1111_2222; if_addr = 16'h0030; dm_addr = 16'h0040; dm_we = 1'b0;
        if_req = 1'b1; dm_req = 1'b1;
        tick(1);
        checks++; if (owner !== 2'd2 || mem_addr !== 16'h0040) begin
            errors++; $display("FAIL tie_first got own=%0d addr=%h exp 2 0040", owner, mem_addr); end
        tick(3);
        checks++; if ({dm_ack, if_ack} !== 2'b10 || dm_rdata !== 32'h1111_2222) begin
            errors++; $display("FAIL tie_dm_done got ack=%b rd=%h exp 10 11112222", {dm_ack, if_ack}, dm_rdata); end
        dm_req = 1'b0; mem_val = 32'h3333_4444;
        tick(1);
        checks++; if (busy !== 1'b0) begin
            errors++; $display("FAIL tie_gap got busy=%b exp 0", busy); end
        tick(1);
        checks++; if (owner !== 2'd1 || mem_addr !== 16'h0030 || mem_en !== 1'b1) begin
            errors++; $display("FAIL tie_second got own=%0d addr=%h en=%b exp 1 0030 1", owner, mem_addr, mem_en); end
        tick(3);
        checks++; if (if_ack !== 1'b1 || if_rdata !== 32'h3333_4444) begin
            errors++; $display("FAIL tie_if_done got ack=%b rd=%h exp 1 33334444", if_ack, if_rdata); end
        if_req = 1'b0;
        tick(1);
        // lone data load, then a tie: round-robin hands this tie to fetch
        dm_addr = 16'h0050; dm_req = 1'b1;
        tick(4);
        dm_req = 1'b0;
        tick(1);
`ifdef MEM_ARB_RR_EN
        exp_first = 2'd1;
`else
        exp_first = 2'd2;
`endif
        if_req = 1'b1; dm_req = 1'b1;
        tick(1);
        checks++; if (owner !== exp_first) begin
            errors++; $display("FAIL tie_after_dm got own=%0d exp %0d", owner, exp_first); end
        tick(3);
        checks++; if ({dm_ack, if_ack} !== ((exp_first == 2'd2) ? 2'b10 : 2'b01)) begin
            errors++; $display("FAIL tie_after_dm_ack got %b exp_owner %0d", {dm_ack, if_ack}, exp_first); end
        if (exp_first == 2'd2) dm_req = 1'b0; else if_req = 1'b0;
        tick(2);
        checks++; if (owner !== 2'd3 - exp_first) begin
            errors++; $display("FAIL tie_after_dm_loser got own=%0d exp %0d", owner, 2'd3 - exp_first); end
        tick(3);
        if_req = 1'b0; dm_req = 1'b0;
        tick(1);
    endtask

    task automatic test_reset_mid();
        int en0, ack0;
        en0 = en_cnt0; ack0 = ifack_cnt;
        mem_val = 32'h5555_5555; if_addr = 16'h0060; if_req = 1'b1;
        tick(2);
        rst_f = 1'b1;
        tick(1);
        checks++; if ({busy, owner, mem_en, mem_we, if_ack, dm_ack} !== 7'd0 || mem_addr !== 16'h0) begin
            errors++; $display("FAIL rst_mid_ctrl got %b addr=%h exp 0", {busy, owner, mem_en, mem_we, if_ack, dm_ack}, mem_addr); end
        checks++; if ({if_rdata, dm_rdata} !== 64'd0) begin
            errors++; $display("FAIL rst_mid_data got %h %h exp 0", if_rdata, dm_rdata); end
        rst_f = 1'b0; if_req = 1'b0;
        tick(10);
        checks++; if (ifack_cnt !== ack0) begin
            errors++; $display("FAIL rst_mid_no_ack got %0d exp %0d", ifack_cnt, ack0); end
        checks++; if (en_cnt0 !== en0 + 1) begin
            errors++; $display("FAIL rst_mid_en_count got %0d exp %0d", en_cnt0, en0 + 1); end
    endtask

    task automatic test_latency_edges();
        int a_cyc, b_cyc, a_en0, b_en0;
        a_cyc = -1; b_cyc = -1; a_en0 = en_cnt1; b_en0 = en_cnt15;
        mem_val = 32'h7777_8888; if_addr = 16'h0070;
        a_if_req = 1'b1; b_if_req = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            tick(1);
            if (a_if_ack && a_cyc < 0) begin a_cyc = k; a_if_req = 1'b0; end
            if (b_if_ack && b_cyc < 0) begin b_cyc = k; b_if_req = 1'b0; end
        end
        a_if_req = 1'b0; b_if_req = 1'b0;
        checks++; if (a_cyc !== 3) begin
            errors++; $display("FAIL lat1_ack_cycle got %0d exp 3", a_cyc); end
        checks++; if (b_cyc !== 17) begin
            errors++; $display("FAIL lat15_ack_cycle got %0d exp 17", b_cyc); end
        checks++; if (a_if_rdata !== 32'h7777_8888 || b_if_rdata !== 32'h7777_8888) begin
            errors++; $display("FAIL lat_edge_rdata got %h %h exp 77778888", a_if_rdata, b_if_rdata); end
        checks++; if (en_cnt1 - a_en0 !== 1 || en_cnt15 - b_en0 !== 1) begin
            errors++; $display("FAIL lat_edge_en_count got %0d %0d exp 1 1", en_cnt1 - a_en0, en_cnt15 - b_en0); end
        checks++; if ({a_busy, b_busy} !== 2'b00) begin
            errors++; $display("FAIL lat_edge_idle got %b exp 00", {a_busy, b_busy}); end
    endtask

    task automatic test_back_to_back();
        int e1, e2, a1, a2, en0;
        logic idle5;
        logic [DW-1:0] rd1;
        e1 = -1; e2 = -1; a1 = -1; a2 = -1; idle5 = 1'b0; rd1 = '0; en0 = en_cnt0;
        mem_val = 32'h0A0A_0A0A; if_addr = 16'h0080; if_req = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick(1);
            if (mem_en) begin
                if (e1 < 0) e1 = k; else if (e2 < 0) e2 = k;
            end
            if (if_ack) begin
                if (a1 < 0) begin a1 = k; rd1 = if_rdata; mem_val = 32'h0B0B_0B0B; end
                else if (a2 < 0) begin a2 = k; if_req = 1'b0; end
            end
            if (k == 5) idle5 = !busy;
        end
        if_req = 1'b0;
        checks++; if (e1 !== 1 || e2 !== 6) begin
            errors++; $display("FAIL b2b_en_cycles got %0d %0d exp 1 6", e1, e2); end
        checks++; if (a1 !== 4 || a2 !== 9) begin
            errors++; $display("FAIL b2b_ack_cycles got %0d %0d exp 4 9", a1, a2); end
        checks++; if (idle5 !== 1'b1) begin
            errors++; $display("FAIL b2b_idle_gap got %b exp 1", idle5); end
        checks++; if (rd1 !== 32'h0A0A_0A0A || if_rdata !== 32'h0B0B_0B0B) begin
            errors++; $display("FAIL b2b_rdata got %h %h exp 0a0a0a0a 0b0b0b0b", rd1, if_rdata); end
        checks++; if (en_cnt0 - en0 !== 2) begin
            errors++; $display("FAIL b2b_en_count got %0d exp 2", en_cnt0 - en0); end
    endtask

    task automatic test_we_strobe();
        checks++; if (we_bad !== 0) begin
            errors++; $display("FAIL we_without_en got %0d exp 0", we_bad); end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store();
        test_tie();
        test_reset_mid();
        test_latency_edges();
        test_back_to_back();
        test_we_strobe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
